// File: rtl/duck_pkg.sv
// rtl/duck_pkg.sv - shared shot-protocol types for the light gun and pattern generator
package duck_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BLACK,
    TARGET,
    REPORT,
    COOLDOWN
  } shot_state_t;

  typedef enum logic [1:0] {
    FM_NORMAL = 2'd0,
    FM_BLACK  = 2'd1,
    FM_TARGET = 2'd2
  } flash_mode_t;

  function automatic flash_mode_t state_flash(input shot_state_t s);
    case (s)
      BLACK:   return FM_BLACK;
      TARGET:  return FM_TARGET;
      default: return FM_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - 2-FF synchronizer plus stable-level counter
// A level change is accepted after STABLE_CYCLES consecutive synchronized samples that disagree with dout.
module debounce #(
  parameter int STABLE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic          r_rise;
  logic          w_accept;

  assign w_accept = (r_sync[1] != r_dout) && (r_cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_dout <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], din};
      r_rise <= w_accept && r_sync[1];
      if (r_sync[1] == r_dout) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt  <= '0;
        r_dout <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;

endmodule

// File: rtl/zapper_shot_ctrl.sv
// rtl/zapper_shot_ctrl.sv - light-gun shot FSM: black/target flash frames, photodiode sampling, hit/miss report
module zapper_shot_ctrl
  import duck_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLACK_FRAMES    = 1,
  parameter int TARGET_FRAMES   = 1,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       detect,
  input  logic       frame_start,
  output logic [1:0] flash_mode,
  output logic       hit,
  output logic       miss,
  output logic       busy
);

  shot_state_t r_state;
  shot_state_t w_next;
  flash_mode_t r_flash_mode;
  flash_mode_t w_flash_mode;
  logic [3:0]  r_frame_cnt;
  logic [1:0]  r_det_sync;
  logic        r_reject;
  logic        r_seen;
  logic        r_hit;
  logic        r_miss;
  logic        r_busy;
  logic        w_hit;
  logic        w_miss;
  logic        w_busy;
  logic        w_trig_level;
  logic        w_trig_rise;
  logic        w_shot;
  logic        w_det;

  debounce #(
    .STABLE_CYCLES(DEBOUNCE_CYCLES)
  ) u_trig_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (trigger),
    .dout (w_trig_level),
    .rise (w_trig_rise)
  );

  assign w_shot = w_trig_rise && w_trig_level && (r_state == IDLE);
  assign w_det  = r_det_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_frame_cnt  <= '0;
      r_det_sync   <= '0;
      r_reject     <= 1'b0;
      r_seen       <= 1'b0;
      r_flash_mode <= FM_NORMAL;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_det_sync   <= {r_det_sync[0], detect};
      r_flash_mode <= w_flash_mode;
      r_hit        <= w_hit;
      r_miss       <= w_miss;
      r_busy       <= w_busy;
      if (w_next != r_state) begin
        r_frame_cnt <= '0;
      end else if (frame_start) begin
        r_frame_cnt <= r_frame_cnt + 4'd1;
      end
      if (r_state == REPORT) begin
        r_reject <= 1'b0;
        r_seen   <= 1'b0;
      end else begin
        if (r_state == BLACK && w_det) r_reject <= 1'b1;
        if (r_state == TARGET && w_det) r_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_shot) w_next = ARM;
      ARM:      if (frame_start) w_next = BLACK;
      BLACK:    if (frame_start && r_frame_cnt == 4'(BLACK_FRAMES - 1)) w_next = TARGET;
      TARGET:   if (frame_start && r_frame_cnt == 4'(TARGET_FRAMES - 1)) w_next = REPORT;
      REPORT:   w_next = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
      COOLDOWN: if (frame_start && r_frame_cnt == 4'(COOLDOWN_FRAMES - 1)) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with r_state.
  always_comb begin
    w_flash_mode = state_flash(w_next);
    w_busy       = (w_next != IDLE);
    w_hit        = (r_state == REPORT) && r_seen && !r_reject;
    w_miss       = (r_state == REPORT) && !(r_seen && !r_reject);
  end

  assign flash_mode = r_flash_mode;
  assign hit        = r_hit;
  assign miss       = r_miss;
  assign busy       = r_busy;

endmodule

// File: tb/tb_zapper_shot_ctrl.sv
// tb/tb_zapper_shot_ctrl.sv - directed bench for zapper_shot_ctrl
module tb_zapper_shot_ctrl;

  logic       clk;
  logic       reset;
  logic       trigger;
  logic       detect;
  logic       frame_start;
  logic [1:0] flash_mode;
  logic       hit;
  logic       miss;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int hit_tot = 0;
  int miss_tot = 0;
  int fm_tot = 0;

  zapper_shot_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BLACK_FRAMES   (1),
    .TARGET_FRAMES  (1),
    .COOLDOWN_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .detect     (detect),
    .frame_start(frame_start),
    .flash_mode (flash_mode),
    .hit        (hit),
    .miss       (miss),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (hit) hit_tot <= hit_tot + 1;
    if (miss) miss_tot <= miss_tot + 1;
    if (flash_mode != 2'b00) fm_tot <= fm_tot + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Trigger rises; sync (2) + debounce (4) puts the shot on the 7th edge.
  task automatic press(input string tag);
    trigger = 1'b1;
    idle(6);
    check({tag, "_busy_pre"}, int'(busy), 0);
    tick();
    check({tag, "_busy_armed"}, int'(busy), 1);
  endtask

  task automatic run_shot(input string tag, input logic lamp, input int exp_hit, input int exp_miss);
    int h0;
    int m0;
    h0 = hit_tot;
    m0 = miss_tot;
    detect = lamp;
    press(tag);
    frame_pulse();
    check({tag, "_fm_black"}, int'(flash_mode), 1);
    idle(99);
    frame_pulse();
    check({tag, "_fm_target"}, int'(flash_mode), 2);
    idle(99);
    frame_pulse();
    idle(2);
    detect = 1'b0;
    idle(97);
    frame_pulse();
    check({tag, "_busy_cd1"}, int'(busy), 1);
    idle(99);
    frame_pulse();
    check({tag, "_busy_done"}, int'(busy), 0);
    check({tag, "_hits"}, hit_tot - h0, exp_hit);
    check({tag, "_misses"}, miss_tot - m0, exp_miss);
    trigger = 1'b0;
    idle(10);
  endtask

  initial begin
    int h0;
    int m0;
    int f0;
    reset = 1'b0;
    trigger = 1'b0;
    detect = 1'b0;
    frame_start = 1'b0;
    idle(3);
    check("rst_flash_mode", int'(flash_mode), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_miss", int'(miss), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    idle(5);

    // 1: hit, trigger held throughout
    h0 = hit_tot;
    m0 = miss_tot;
    press("t1");
    frame_pulse();
    check("t1_fm_black", int'(flash_mode), 1);
    idle(99);
    frame_pulse();
    check("t1_fm_target", int'(flash_mode), 2);
    detect = 1'b1;
    idle(80);
    detect = 1'b0;
    idle(19);
    frame_pulse();
    check("t1_fm_report", int'(flash_mode), 0);
    check("t1_hit_not_yet", int'(hit), 0);
    tick();
    check("t1_hit_pulse", int'(hit), 1);
    check("t1_miss_low", int'(miss), 0);
    tick();
    check("t1_hit_cleared", int'(hit), 0);
    idle(97);
    frame_pulse();
    check("t1_busy_cd1", int'(busy), 1);
    idle(99);
    frame_pulse();
    check("t1_busy_done", int'(busy), 0);
    check("t1_hits", hit_tot - h0, 1);
    check("t1_misses", miss_tot - m0, 0);
    idle(20);
    check("t1_no_refire", int'(busy), 0);
    trigger = 1'b0;
    idle(10);

    // 2: dark target -> miss; 3: lamp -> reject -> miss
    run_shot("t2", 1'b0, 0, 1);
    run_shot("t3", 1'b1, 0, 1);

    // 4: bouncing trigger, then a press during cooldown
    for (int i = 0; i < 5; i++) begin
      trigger = 1'b1;
      idle(2);
      trigger = 1'b0;
      idle(2);
    end
    check("t4_bounce_no_shot", int'(busy), 0);
    h0 = hit_tot;
    m0 = miss_tot;
    press("t4");
    frame_pulse();
    idle(99);
    frame_pulse();
    idle(99);
    frame_pulse();
    idle(2);
    f0 = fm_tot;
    trigger = 1'b0;
    idle(10);
    trigger = 1'b1;
    idle(10);
    check("t4_busy_cd", int'(busy), 1);
    idle(77);
    frame_pulse();
    check("t4_busy_cd1", int'(busy), 1);
    idle(99);
    frame_pulse();
    check("t4_busy_done", int'(busy), 0);
    check("t4_fm_normal_cd", fm_tot - f0, 0);
    check("t4_hits", hit_tot - h0, 0);
    check("t4_misses", miss_tot - m0, 1);
    idle(20);
    check("t4_no_queue", int'(busy), 0);
    trigger = 1'b0;
    idle(10);

    // 5: shot edge coincides with frame_start
    trigger = 1'b1;
    idle(6);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t5_busy", int'(busy), 1);
    check("t5_fm_arm", int'(flash_mode), 0);
    idle(99);
    check("t5_fm_still_arm", int'(flash_mode), 0);
    frame_pulse();
    check("t5_fm_black", int'(flash_mode), 1);
    idle(99);
    frame_pulse();
    check("t5_fm_target", int'(flash_mode), 2);
    idle(99);
    frame_pulse();
    idle(99);
    frame_pulse();
    idle(99);
    frame_pulse();
    check("t5_busy_done", int'(busy), 0);
    trigger = 1'b0;
    idle(10);

    // 6: asynchronous reset during TARGET with light seen
    press("t6");
    frame_pulse();
    idle(99);
    frame_pulse();
    detect = 1'b1;
    idle(20);
    check("t6_fm_target", int'(flash_mode), 2);
    check("t6_busy", int'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_fm", int'(flash_mode), 0);
    check("t6_async_busy", int'(busy), 0);
    tick();
    trigger = 1'b0;
    detect = 1'b0;
    tick();
    h0 = hit_tot;
    m0 = miss_tot;
    reset = 1'b1;
    idle(50);
    frame_pulse();
    idle(50);
    check("t6_no_hit", hit_tot - h0, 0);
    check("t6_no_miss", miss_tot - m0, 0);
    check("t6_busy_after", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
